// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_unit
// Purpose  : RV32I integer execution unit. It accepts one dispatched
//            non-memory operation per cycle and registers the result with a
//            latency of one cycle. It broadcasts the result together with its
//            ROB index. For branches and jumps it also resolves the next PC.
//            Load/store opcodes belong to the LSB and are treated as bubbles.
// Ports    : clk, rst (sync, active-high), rdy (global enable), flush
//            in_opcode/in_val1/in_val2/in_imm/in_pc/in_rob_index : dispatch
//            out_valid/out_res/out_rob_index                     : result
//            out_is_jump/out_br_taken/out_next_pc                : control
// Revision : 1.0 - initial release
// ============================================================================
module alu_unit #(
  parameter int ROB_W = 6,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic [OP_W-1:0]  in_opcode,
  input  logic [31:0]      in_val1,
  input  logic [31:0]      in_val2,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_pc,
  input  logic [ROB_W-1:0] in_rob_index,
  output logic             out_valid,
  output logic [31:0]      out_res,
  output logic [ROB_W-1:0] out_rob_index,
  output logic             out_is_jump,
  output logic             out_br_taken,
  output logic [31:0]      out_next_pc
);

  // Opcode map
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(20);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(21);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(22);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(23);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(24);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(25);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(26);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(27);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(28);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(29);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(30);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(31);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(32);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(33);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(34);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(35);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(36);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(37);

  // Result registers
  logic             valid_q,    valid_d;
  logic [31:0]      res_q,      res_d;
  logic [ROB_W-1:0] rob_q,      rob_d;
  logic             is_jump_q,  is_jump_d;
  logic             taken_q,    taken_d;
  logic [31:0]      next_pc_q,  next_pc_d;

  // Combinational execute datapath
  logic        is_exec;
  logic [31:0] op2;
  logic [4:0]  shamt;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic [31:0] jalr_tgt;
  logic        lt_s;
  logic        lt_u;
  logic        eq;
  logic [31:0] alu_res;
  logic        alu_jump;
  logic        alu_taken;
  logic [31:0] alu_next;

  // Loads/stores (11..18) sit in a hole between the two execute ranges
  assign is_exec = ((in_opcode >= OP_LUI)  && (in_opcode <= OP_BGEU)) ||
                   ((in_opcode >= OP_ADDI) && (in_opcode <= OP_AND));

  // The I-type range uses the immediate as second operand
  assign op2         = ((in_opcode >= OP_ADDI) && (in_opcode <= OP_SRAI)) ? in_imm : in_val2;
  assign shamt       = op2[4:0];
  assign pc_plus4    = in_pc + 32'd4;
  assign pc_plus_imm = in_pc + in_imm;
  assign jalr_tgt    = (in_val1 + in_imm) & ~32'd1;
  assign lt_s        = $signed(in_val1) < $signed(op2);
  assign lt_u        = in_val1 < op2;
  assign eq          = in_val1 == op2;

  always_comb begin
    alu_res   = 32'd0;
    alu_jump  = 1'b0;
    alu_taken = 1'b0;
    alu_next  = pc_plus4;
    case (in_opcode)
      OP_LUI:   alu_res = in_imm;
      OP_AUIPC: alu_res = pc_plus_imm;
      OP_JAL: begin
        alu_res   = pc_plus4;
        alu_jump  = 1'b1;
        alu_taken = 1'b1;
        alu_next  = pc_plus_imm;
      end
      OP_JALR: begin
        alu_res   = pc_plus4;
        alu_jump  = 1'b1;
        alu_taken = 1'b1;
        alu_next  = jalr_tgt;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        alu_jump = 1'b1;
        case (in_opcode)
          OP_BEQ:  alu_taken = eq;
          OP_BNE:  alu_taken = ~eq;
          OP_BLT:  alu_taken = lt_s;
          OP_BGE:  alu_taken = ~lt_s;
          OP_BLTU: alu_taken = lt_u;
          default: alu_taken = ~lt_u;
        endcase
        alu_next = alu_taken ? pc_plus_imm : pc_plus4;
      end
      OP_ADDI, OP_ADD:   alu_res = in_val1 + op2;
      OP_SUB:            alu_res = in_val1 - op2;
      OP_SLTI, OP_SLT:   alu_res = {31'd0, lt_s};
      OP_SLTIU, OP_SLTU: alu_res = {31'd0, lt_u};
      OP_XORI, OP_XOR:   alu_res = in_val1 ^ op2;
      OP_ORI, OP_OR:     alu_res = in_val1 | op2;
      OP_ANDI, OP_AND:   alu_res = in_val1 & op2;
      OP_SLLI, OP_SLL:   alu_res = in_val1 << shamt;
      OP_SRLI, OP_SRL:   alu_res = in_val1 >> shamt;
      OP_SRAI, OP_SRA:   alu_res = $unsigned($signed(in_val1) >>> shamt);
      default:           alu_res = 32'd0;
    endcase
  end

  // Next-state: hold everything while rdy is low; flush kills the op but the
  // data fields still follow the inputs (they are don't-care when invalid).
  always_comb begin
    valid_d   = valid_q;
    res_d     = res_q;
    rob_d     = rob_q;
    is_jump_d = is_jump_q;
    taken_d   = taken_q;
    next_pc_d = next_pc_q;
    if (rdy) begin
      valid_d   = is_exec & ~flush;
      res_d     = alu_res;
      rob_d     = in_rob_index;
      is_jump_d = alu_jump & ~flush;
      taken_d   = alu_taken & ~flush;
      next_pc_d = alu_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      res_q     <= 32'd0;
      rob_q     <= '0;
      is_jump_q <= 1'b0;
      taken_q   <= 1'b0;
      next_pc_q <= 32'd0;
    end else begin
      valid_q   <= valid_d;
      res_q     <= res_d;
      rob_q     <= rob_d;
      is_jump_q <= is_jump_d;
      taken_q   <= taken_d;
      next_pc_q <= next_pc_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_res       = res_q;
  assign out_rob_index = rob_q;
  assign out_is_jump   = is_jump_q;
  assign out_br_taken  = taken_q;
  assign out_next_pc   = next_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_unit
// Purpose  : Self-checking bench for alu_unit. A behavioural model predicts
//            the registered outputs every cycle; directed vectors also carry
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic [5:0]  in_opcode = '0;
  logic [31:0] in_val1 = '0, in_val2 = '0, in_imm = '0, in_pc = '0;
  logic [5:0]  in_rob_index = '0;
  logic        out_valid;
  logic [31:0] out_res;
  logic [5:0]  out_rob_index;
  logic        out_is_jump;
  logic        out_br_taken;
  logic [31:0] out_next_pc;

  int n_checks = 0;
  int n_fail   = 0;

  alu_unit #(.ROB_W(6), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_opcode(in_opcode), .in_val1(in_val1), .in_val2(in_val2),
    .in_imm(in_imm), .in_pc(in_pc), .in_rob_index(in_rob_index),
    .out_valid(out_valid), .out_res(out_res), .out_rob_index(out_rob_index),
    .out_is_jump(out_is_jump), .out_br_taken(out_br_taken),
    .out_next_pc(out_next_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] res;
    logic [5:0]  rob;
    logic        jump;
    logic        taken;
    logic [31:0] npc;
    logic        full;   // every field is meaningful
    logic        ctrl;   // jump/taken are meaningful (flush)
  } exp_t;

  // Architectural semantics of one dispatched operation
  function automatic exp_t model(input int op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [5:0] rob, input logic fl);
    exp_t e;
    logic [31:0] o2;
    int sh;
    logic t;
    e = '0;
    o2 = (op >= 19 && op <= 27) ? imm : b;
    sh = int'(o2 % 32);
    e.rob = rob;
    e.npc = pc + 4;
    t = 1'b0;
    if (op == 1) e.res = imm;
    else if (op == 2) e.res = pc + imm;
    else if (op == 3 || op == 4) begin
      e.res = pc + 4; e.jump = 1; t = 1;
      e.npc = (op == 3) ? pc + imm : ((a + imm) & 32'hFFFF_FFFE);
    end else if (op >= 5 && op <= 10) begin
      e.jump = 1;
      case (op)
        5: t = (a == b);
        6: t = (a != b);
        7: t = ($signed(a) < $signed(b));
        8: t = !($signed(a) < $signed(b));
        9: t = (a < b);
        default: t = (a >= b);
      endcase
      if (t) e.npc = pc + imm;
    end else if (op == 19 || op == 28) e.res = a + o2;
    else if (op == 29) e.res = a - o2;
    else if (op == 20 || op == 31) e.res = ($signed(a) < $signed(o2)) ? 1 : 0;
    else if (op == 21 || op == 32) e.res = (a < o2) ? 1 : 0;
    else if (op == 22 || op == 33) e.res = a ^ o2;
    else if (op == 23 || op == 36) e.res = a | o2;
    else if (op == 24 || op == 37) e.res = a & o2;
    else if (op == 25 || op == 30) e.res = a * (32'd1 << sh);
    else if (op == 26 || op == 34) e.res = a / (32'd1 << sh);
    else if (op == 27 || op == 35) begin
      e.res = a >> sh;
      if (a[31]) e.res = e.res | ~(32'hFFFF_FFFF >> sh);
    end
    e.taken = t;
    e.valid = ((op >= 1 && op <= 10) || (op >= 19 && op <= 37)) && !fl;
    if (fl) begin e.jump = 0; e.taken = 0; e.ctrl = 1; end
    e.full = e.valid;
    return e;
  endfunction

  exp_t m;
  logic started = 1'b0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m <= '0;
      m.full <= 1'b1;
    end else if (rdy) begin
      m <= model(int'(in_opcode), in_val1, in_val2, in_imm, in_pc, in_rob_index, flush);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Model-based compare, every cycle
  always @(negedge clk) begin
    if (started) begin
      chk("cmp_valid", {31'd0, out_valid}, {31'd0, m.valid});
      if (m.full) begin
        chk("cmp_res", out_res, m.res);
        chk("cmp_rob", {26'd0, out_rob_index}, {26'd0, m.rob});
        chk("cmp_jump", {31'd0, out_is_jump}, {31'd0, m.jump});
        chk("cmp_taken", {31'd0, out_br_taken}, {31'd0, m.taken});
        chk("cmp_npc", out_next_pc, m.npc);
      end else if (m.ctrl) begin
        chk("cmp_jump", {31'd0, out_is_jump}, {31'd0, m.jump});
        chk("cmp_taken", {31'd0, out_br_taken}, {31'd0, m.taken});
      end
    end
  end

  task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] p,
                       input logic [5:0] rob, input logic fl);
    @(negedge clk);
    in_opcode = 6'(op); in_val1 = a; in_val2 = b; in_imm = im; in_pc = p;
    in_rob_index = rob; flush = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst = 1'b1;
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res", out_res, 32'd0);
    chk("rst_npc", out_next_pc, 32'd0);
    @(negedge clk); rst = 1'b0;

    // ADD 5+7 then a bubble
    drive(28, 32'd5, 32'd7, 32'd0, 32'h0, 6'd3, 0); tick();
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_res", out_res, 32'd12);
    chk("add_rob", {26'd0, out_rob_index}, 32'd3);
    chk("add_jump", {31'd0, out_is_jump}, 32'd0);
    drive(0, 32'd0, 32'd0, 32'd0, 32'h0, 6'd0, 0); tick();
    chk("nop_valid", {31'd0, out_valid}, 32'd0);

    // Shifts and compares
    drive(27, 32'h8000_0000, 32'd0, 32'h24, 32'h0, 6'd1, 0); tick();
    chk("srai_res", out_res, 32'hF800_0000);
    drive(26, 32'h8000_0000, 32'd0, 32'h24, 32'h0, 6'd2, 0); tick();
    chk("srli_res", out_res, 32'h0800_0000);
    drive(32, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 6'd4, 0); tick();
    chk("sltu_res", out_res, 32'd0);
    drive(31, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 6'd5, 0); tick();
    chk("slt_res", out_res, 32'd1);
    drive(29, 32'd0, 32'd1, 32'd0, 32'h0, 6'd6, 0); tick();
    chk("sub_wrap", out_res, 32'hFFFF_FFFF);
    drive(30, 32'h0000_0003, 32'h0000_0021, 32'd0, 32'h0, 6'd7, 0); tick();
    chk("sll_res", out_res, 32'h0000_0006);

    // Branches and jumps
    drive(7, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 6'd8, 0); tick();
    chk("blt_jump", {31'd0, out_is_jump}, 32'd1);
    chk("blt_taken", {31'd0, out_br_taken}, 32'd1);
    chk("blt_npc", out_next_pc, 32'h120);
    drive(10, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 6'd8, 0); tick();
    chk("bgeu_taken", {31'd0, out_br_taken}, 32'd1);
    chk("bgeu_npc", out_next_pc, 32'h120);
    drive(6, 32'd4, 32'd4, 32'h20, 32'h200, 6'd8, 0); tick();
    chk("bne_taken", {31'd0, out_br_taken}, 32'd0);
    chk("bne_npc", out_next_pc, 32'h204);
    drive(4, 32'h1003, 32'd0, 32'd2, 32'h40, 6'd9, 0); tick();
    chk("jalr_res", out_res, 32'h44);
    chk("jalr_npc", out_next_pc, 32'h1004);
    chk("jalr_taken", {31'd0, out_br_taken}, 32'd1);
    chk("jalr_rob", {26'd0, out_rob_index}, 32'd9);
    drive(3, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h80, 6'd10, 0); tick();
    chk("jal_npc", out_next_pc, 32'h70);
    drive(2, 32'd0, 32'd0, 32'h1000, 32'h80, 6'd11, 0); tick();
    chk("auipc_res", out_res, 32'h1080);

    // Flush and bubbles
    drive(28, 32'd1, 32'd1, 32'd0, 32'h0, 6'd12, 1); tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    drive(3, 32'd0, 32'd0, 32'h8, 32'h0, 6'd12, 1); tick();
    chk("flush_jump", {31'd0, out_is_jump}, 32'd0);
    drive(28, 32'd1, 32'd1, 32'd0, 32'h0, 6'd13, 0); tick();
    chk("b2b_v0", {31'd0, out_valid}, 32'd1);
    drive(28, 32'd2, 32'd2, 32'd0, 32'h0, 6'd14, 1); tick();
    chk("b2b_v1", {31'd0, out_valid}, 32'd0);
    drive(28, 32'd3, 32'd3, 32'd0, 32'h0, 6'd15, 0); tick();
    chk("b2b_v2", {31'd0, out_valid}, 32'd1);
    chk("b2b_res", out_res, 32'd6);
    drive(14, 32'd3, 32'd3, 32'd0, 32'h0, 6'd16, 0); tick();
    chk("store_valid", {31'd0, out_valid}, 32'd0);

    // Stall right after a valid result
    drive(28, 32'd1, 32'd2, 32'd0, 32'h0, 6'd17, 0); tick();
    chk("pre_stall_res", out_res, 32'd3);
    @(negedge clk);
    rdy = 1'b0; in_opcode = 6'd29; in_val1 = 32'd9; in_val2 = 32'd4; in_rob_index = 6'd20;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_res", out_res, 32'd3);
    end
    drive(0, 32'd0, 32'd0, 32'd0, 32'h0, 6'd0, 0);
    rdy = 1'b1;
    tick();
    chk("post_stall_valid", {31'd0, out_valid}, 32'd0);

    // Reset while a valid result is showing
    drive(3, 32'd0, 32'd0, 32'h10, 32'h300, 6'd21, 0); tick();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    drive(28, 32'd5, 32'd5, 32'd0, 32'h0, 6'd22, 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_res", out_res, 32'd0);
    chk("mid_rst_rob", {26'd0, out_rob_index}, 32'd0);
    chk("mid_rst_jump", {31'd0, out_is_jump}, 32'd0);
    chk("mid_rst_taken", {31'd0, out_br_taken}, 32'd0);
    chk("mid_rst_npc", out_next_pc, 32'd0);
    @(negedge clk); rst = 1'b0;
    drive(0, 32'd0, 32'd0, 32'd0, 32'h0, 6'd0, 0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
